// File: rtl/vga_pkg.sv
// Shared 800x600@72 Hz VGA timing constants, pixel format and capture FSM encoding.
// Used by both the display-side pipeline and the frame-capture block.
package vga_pkg;

  // Horizontal timing, in pixel clocks
  localparam int unsigned H_SYNC   = 120;
  localparam int unsigned H_BP     = 64;
  localparam int unsigned H_ACTIVE = 800;
  localparam int unsigned H_FP     = 56;

  // Vertical timing, in lines
  localparam int unsigned V_SYNC   = 6;
  localparam int unsigned V_BP     = 23;
  localparam int unsigned V_ACTIVE = 600;
  localparam int unsigned V_FP     = 37;

  // Pixel format {R[11:8], G[7:4], B[3:0]}
  localparam int unsigned RGB_W    = 12;

  // Capture decimation and VRAM address width
  localparam int unsigned SCALE    = 4;
  localparam int unsigned DW       = 15;

  typedef enum logic [1:0] {
    StIdle,
    StWaitVs,
    StCapture
  } cap_state_t;

endpackage

// File: rtl/vga_sync_tracker.sv
// Registers the incoming VGA stream, detects sync edges and tracks the pixel position.
// The position and sample strobe are aligned with the registered pixel rgb_q (pix).
module vga_sync_tracker #(
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned SCALE    = vga_pkg::SCALE
) (
  input  logic                       pclk,
  input  logic                       rst,
  input  logic                       hs,
  input  logic                       vs,
  input  logic [vga_pkg::RGB_W-1:0]  rgb,
  output logic [vga_pkg::RGB_W-1:0]  pix,
  output logic                       vs_rise,
  output logic                       sample
);

  localparam logic [10:0] HOFF  = 11'(H_SYNC + H_BP);
  localparam logic [10:0] HEND  = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] VOFF  = 11'(V_SYNC + V_BP);
  localparam logic [10:0] VEND  = 11'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [10:0] SMASK = 11'(SCALE - 1);
  localparam logic [10:0] CMAX  = 11'h7ff;

  logic                      hs_q, hs_qq, vs_q, vs_qq;
  logic [vga_pkg::RGB_W-1:0] rgb_q;
  logic [10:0]               h_cnt_q, v_cnt_q, h_cnt, v_cnt, x, y;
  logic                      hs_rise, x_act, y_act;

  // Input register stage plus a second sync copy for edge detection
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hs_q    <= 1'b0;
      hs_qq   <= 1'b0;
      vs_q    <= 1'b0;
      vs_qq   <= 1'b0;
      rgb_q   <= '0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      hs_q    <= hs;
      hs_qq   <= hs_q;
      vs_q    <= vs;
      vs_qq   <= vs_q;
      rgb_q   <= rgb;
      h_cnt_q <= h_cnt;
      v_cnt_q <= v_cnt;
    end
  end

  assign hs_rise = hs_q & ~hs_qq;
  assign vs_rise = vs_q & ~vs_qq;

  // Position of the pixel now in rgb_q: h_cnt is 0 in the cycle hs_q first reads high
  always_comb begin
    h_cnt = (h_cnt_q == CMAX) ? h_cnt_q : h_cnt_q + 11'd1;
    if (hs_rise) h_cnt = '0;
    v_cnt = v_cnt_q;
    if (vs_rise) begin
      v_cnt = '0;
    end else if (hs_rise && v_cnt_q != CMAX) begin
      v_cnt = v_cnt_q + 11'd1;
    end
  end

  assign x      = h_cnt - HOFF;
  assign y      = v_cnt - VOFF;
  assign x_act  = (h_cnt >= HOFF) && (h_cnt < HEND);
  assign y_act  = (v_cnt >= VOFF) && (v_cnt < VEND);
  assign sample = x_act && y_act && ((x & SMASK) == '0) && ((y & SMASK) == '0);
  assign pix    = rgb_q;

endmodule

// File: rtl/vga_frame_capture.sv
// Captures one (or a stream of) decimated VGA frames into a VRAM write port.
// Writes arrive in raster order, so the VRAM address is a plain write counter.
module vga_frame_capture #(
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned SCALE    = vga_pkg::SCALE,
  parameter int unsigned DW       = vga_pkg::DW
) (
  input  logic                      pclk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      cont,
  input  logic                      hs,
  input  logic                      vs,
  input  logic [vga_pkg::RGB_W-1:0] rgb,
  output logic                      we,
  output logic [DW-1:0]             waddr,
  output logic [vga_pkg::RGB_W-1:0] wdata,
  output logic                      busy,
  output logic                      done,
  output logic                      frame_err
);

  localparam int unsigned H_LEN = H_ACTIVE / SCALE;
  localparam int unsigned V_LEN = V_ACTIVE / SCALE;
  localparam logic [DW-1:0] LAST = DW'(H_LEN * V_LEN - 1);

  vga_pkg::cap_state_t       state;
  logic [DW-1:0]             wcnt;
  logic [vga_pkg::RGB_W-1:0] pix;
  logic                      vs_rise, sample;

  vga_sync_tracker #(
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .H_ACTIVE (H_ACTIVE),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .V_ACTIVE (V_ACTIVE),
    .SCALE    (SCALE)
  ) u_sync (
    .pclk    (pclk),
    .rst     (rst),
    .hs      (hs),
    .vs      (vs),
    .rgb     (rgb),
    .pix     (pix),
    .vs_rise (vs_rise),
    .sample  (sample)
  );

  // Capture FSM with registered VRAM port; busy drops one cycle after leaving capture
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state     <= vga_pkg::StIdle;
      wcnt      <= '0;
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      unique case (state)
        vga_pkg::StIdle: begin
          busy <= 1'b0;
          if (start) begin
            state     <= vga_pkg::StWaitVs;
            busy      <= 1'b1;
            frame_err <= 1'b0;
          end
        end
        vga_pkg::StWaitVs: begin
          if (vs_rise) begin
            state <= vga_pkg::StCapture;
            wcnt  <= '0;
          end
        end
        vga_pkg::StCapture: begin
          if (vs_rise) begin
            // New frame began before the image was complete
            frame_err <= 1'b1;
            state     <= vga_pkg::StIdle;
          end else if (sample) begin
            we    <= 1'b1;
            waddr <= wcnt;
            wdata <= pix;
            wcnt  <= wcnt + DW'(1);
            if (wcnt == LAST) begin
              done  <= 1'b1;
              state <= cont ? vga_pkg::StWaitVs : vga_pkg::StIdle;
            end
          end
        end
        default: state <= vga_pkg::StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture using a shrunken timing (16x12 active, 4x3 image)
// so each frame is 28x18 clocks; expected values are derived from the pixel pattern.
module tb_vga_frame_capture;

  localparam int HS = 4, HBP = 4, HA = 16, HFP = 4;
  localparam int VS = 2, VBP = 2, VA = 12, VFP = 2;
  localparam int HT = HS + HBP + HA + HFP;
  localparam int VT = VS + VBP + VA + VFP;
  localparam int HOFF = HS + HBP;
  localparam int VOFF = VS + VBP;
  localparam int HL = HA / 4;
  localparam int NW = HL * (VA / 4);

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        hs = 1'b0;
  logic        vs = 1'b0;
  logic [11:0] rgb = '0;
  logic        we, busy, done, frame_err;
  logic [14:0] waddr;
  logic [11:0] wdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int spot_cyc = 0;

  // Write / done log
  logic [14:0] wa[$];
  logic [11:0] wd[$];
  int          wc[$];
  int          dc[$];
  logic [14:0] da[$];
  logic        dwe[$];
  logic        done_prev = 1'b0;
  logic        busy_at = 1'b0;
  logic        busy_after = 1'b1;
  logic        saw_busy = 1'b0;
  logic        saw_err = 1'b0;

  vga_frame_capture #(
    .H_SYNC   (HS),
    .H_BP     (HBP),
    .H_ACTIVE (HA),
    .V_SYNC   (VS),
    .V_BP     (VBP),
    .V_ACTIVE (VA),
    .SCALE    (4),
    .DW       (15)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .start     (start),
    .cont      (cont),
    .hs        (hs),
    .vs        (vs),
    .rgb       (rgb),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .frame_err (frame_err)
  );

  always #10 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk) begin
    if (we) begin
      wa.push_back(waddr);
      wd.push_back(wdata);
      wc.push_back(cyc);
    end
    if (done) begin
      dc.push_back(cyc);
      da.push_back(waddr);
      dwe.push_back(we);
      busy_at = busy;
    end
    if (done_prev) busy_after = busy;
    done_prev = done;
    if (busy) saw_busy = 1'b1;
    if (frame_err) saw_err = 1'b1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, required to have finished");
    $fatal(1, "watchdog");
  end

  task automatic clear_log;
    @(negedge pclk);
    #1;
    wa.delete(); wd.delete(); wc.delete();
    dc.delete(); da.delete(); dwe.delete();
    saw_busy = 1'b0;
    saw_err = 1'b0;
    busy_at = 1'b0;
    busy_after = 1'b1;
  endtask

  task automatic pulse_start;
    @(negedge pclk);
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
  endtask

  // mode 0: {x[5:2],y[5:2],5}; mode 1: 12'hABC at (0,0), zero elsewhere
  task automatic drive_lines(input int nlines, input int mode);
    logic [11:0] xv, yv;
    for (int l = 0; l < nlines; l++) begin
      for (int c = 0; c < HT; c++) begin
        int ll, x, y;
        @(negedge pclk);
        ll = l % VT;
        x  = c - HOFF;
        y  = ll - VOFF;
        hs = (c < HS);
        vs = (ll < VS);
        xv = 12'(x);
        yv = 12'(y);
        if (x >= 0 && x < HA && y >= 0 && y < VA) begin
          if (mode == 0) begin
            rgb = {xv[5:2], yv[5:2], 4'h5};
          end else if (x == 0 && y == 0) begin
            rgb = 12'hABC;
            spot_cyc = cyc;
          end else begin
            rgb = 12'h000;
          end
        end else begin
          rgb = 12'h000;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge pclk);
    #1;
    n_cmp++;
    if ({we, done, busy, frame_err} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b required 0000", {we, done, busy, frame_err});
    end
    n_cmp++;
    if (waddr !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_waddr: got %0d required 0", waddr);
    end
    n_cmp++;
    if (wdata !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_wdata: got %h required 000", wdata);
    end
    rst = 1'b0;
    clear_log();
    fork
      drive_lines(2 * VT, 0);
      begin
        repeat (300) @(negedge pclk);
        rst = 1'b1;
        @(negedge pclk);
        rst = 1'b0;
      end
    join
    @(negedge pclk);
    #1;
    n_cmp++;
    if (wa.size() != 0) begin
      n_bad++;
      $display("FAIL idle_writes: got %0d required 0", wa.size());
    end
    n_cmp++;
    if (dc.size() != 0 || saw_busy !== 1'b0 || saw_err !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_status: done=%0d busy=%b err=%b required 0/0/0",
               dc.size(), saw_busy, saw_err);
    end
  endtask

  task automatic test_single_frame;
    clear_log();
    cont = 1'b0;
    pulse_start();
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_after_start: got %b required 1", busy);
    end
    drive_lines(VT, 0);
    @(negedge pclk);
    #1;
    n_cmp++;
    if (wa.size() != NW) begin
      n_bad++;
      $display("FAIL single_count: got %0d required %0d", wa.size(), NW);
    end else begin
      for (int k = 0; k < NW; k++) begin
        logic [11:0] exp_d;
        exp_d = {4'(k % HL), 4'(k / HL), 4'h5};
        n_cmp++;
        if (wa[k] !== 15'(k) || wd[k] !== exp_d) begin
          n_bad++;
          $display("FAIL single_write%0d: got addr %0d data %h required addr %0d data %h",
                   k, wa[k], wd[k], k, exp_d);
        end
      end
      n_cmp++;
      if (wd[5] !== 12'h115) begin
        n_bad++;
        $display("FAIL single_x4y4: got %h required 115", wd[5]);
      end
      n_cmp++;
      if (dc.size() != 1 || dc[0] != wc[NW-1] || da[0] !== 15'd11 || dwe[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL single_done: got %0d pulses required 1 coincident with waddr 11",
                 dc.size());
      end
    end
    n_cmp++;
    if (busy_at !== 1'b1 || busy_after !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_busy: got at_done=%b next=%b now=%b required 1/0/0",
               busy_at, busy_after, busy);
    end
  endtask

  task automatic test_latency;
    clear_log();
    pulse_start();
    drive_lines(VT, 1);
    @(negedge pclk);
    #1;
    n_cmp++;
    if (wa.size() != NW) begin
      n_bad++;
      $display("FAIL latency_count: got %0d required %0d", wa.size(), NW);
    end else begin
      n_cmp++;
      if (wc[0] - spot_cyc != 2) begin
        n_bad++;
        $display("FAIL latency_cycles: got %0d required 2", wc[0] - spot_cyc);
      end
      n_cmp++;
      if (wa[0] !== 15'd0 || wd[0] !== 12'hABC) begin
        n_bad++;
        $display("FAIL latency_pixel: got addr %0d data %h required addr 0 data abc",
                 wa[0], wd[0]);
      end
      n_cmp++;
      if (wd[1] !== 12'h000) begin
        n_bad++;
        $display("FAIL latency_next: got %h required 000", wd[1]);
      end
    end
  endtask

  task automatic test_continuous;
    clear_log();
    cont = 1'b1;
    pulse_start();
    drive_lines(3 * VT, 0);
    @(negedge pclk);
    #1;
    n_cmp++;
    if (wa.size() != 3 * NW || dc.size() != 3) begin
      n_bad++;
      $display("FAIL cont_counts: got %0d writes %0d done required %0d/3",
               wa.size(), dc.size(), 3 * NW);
    end else begin
      n_cmp++;
      if (wa[0] !== 15'd0 || wa[NW] !== 15'd0 || wa[2*NW] !== 15'd0 || wa[3*NW-1] !== 15'd11)
      begin
        n_bad++;
        $display("FAIL cont_restart: got %0d %0d %0d last %0d required 0 0 0 last 11",
                 wa[0], wa[NW], wa[2*NW], wa[3*NW-1]);
      end
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL cont_rearmed: got busy %b required 1", busy);
    end
    cont = 1'b0;
    drive_lines(VT, 0);
    @(negedge pclk);
    #1;
    n_cmp++;
    if (wa.size() != 4 * NW || dc.size() != 4 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL cont_stop: got %0d writes %0d done busy %b required %0d/4/0",
               wa.size(), dc.size(), busy, 4 * NW);
    end
  endtask

  task automatic test_short_frame;
    clear_log();
    cont = 1'b0;
    pulse_start();
    drive_lines(VOFF + VA / 2 + 1, 0);
    drive_lines(VS + 2, 0);
    @(negedge pclk);
    #1;
    n_cmp++;
    if (frame_err !== 1'b1) begin
      n_bad++;
      $display("FAIL short_err: got %b required 1", frame_err);
    end
    n_cmp++;
    if (dc.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL short_state: got done=%0d busy=%b required 0/0", dc.size(), busy);
    end
    n_cmp++;
    if (wa.size() != 8) begin
      n_bad++;
      $display("FAIL short_writes: got %0d required 8", wa.size());
    end
    pulse_start();
    #1;
    n_cmp++;
    if (frame_err !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL short_restart: got err=%b busy=%b required 0/1", frame_err, busy);
    end
  endtask

  task automatic test_reset_mid;
    logic hit;
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    clear_log();
    pulse_start();
    hit = 1'b0;
    fork
      drive_lines(2 * VT, 0);
      begin
        for (int i = 0; i < 2000 && !hit; i++) begin
          @(negedge pclk);
          #1;
          if (wa.size() >= NW / 2) hit = 1'b1;
        end
        if (hit) begin
          rst = 1'b1;
          #1;
          n_cmp++;
          if ({we, done, busy, frame_err} !== 4'b0000 || waddr !== 15'd0 || wdata !== 12'h000)
          begin
            n_bad++;
            $display("FAIL midrst_outputs: got flags %b addr %0d data %h required all 0",
                     {we, done, busy, frame_err}, waddr, wdata);
          end
          repeat (2) @(negedge pclk);
          rst = 1'b0;
        end
      end
    join
    n_cmp++;
    if (hit !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_reach: got %0d writes before timeout required %0d", wa.size(),
               NW / 2);
    end
    @(negedge pclk);
    #1;
    n_cmp++;
    if (wa.size() != NW / 2 || dc.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_after: got %0d writes %0d done busy %b required %0d/0/0",
               wa.size(), dc.size(), busy, NW / 2);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_latency();
    test_continuous();
    test_short_frame();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_frame_capture.md
# vga_frame_capture

Receive-side counterpart of the VGA display path: samples an incoming 800x600@72 Hz VGA stream (hs, vs, 12-bit RGB on the 50 MHz pixel clock), decimates it 4:1 in both axes and writes the resulting 200x150 image into a 12-bit x 32768 VRAM write port. Sits between a VGA source (the DST/DDP display pipeline in loopback, or an external source) and the write side of the frame-buffer VRAM. Software arms it with a one-cycle start pulse and gets one complete frame, or a continuous stream of frames, at VRAM addresses 0..29999.

## Interface
- H_SYNC, 120: hs pulse width, pixels
- H_BP, 64: horizontal back porch, pixels
- H_ACTIVE, 800: active pixels per line
- V_SYNC, 6: vs pulse width, lines
- V_BP, 23: vertical back porch, lines
- V_ACTIVE, 600: active lines
- SCALE, 4: decimation factor, both axes (power of two)
- DW, 15: VRAM address width
- H_LEN, 200: stored image width (H_ACTIVE/SCALE)
- V_LEN, 150: stored image height (V_ACTIVE/SCALE)

- pclk  in  1  50 MHz pixel clock, sole clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle arm request, honoured only in IDLE
- cont  in  1  sampled at end of frame: 1 = re-arm automatically
- hs  in  1  horizontal sync, high during sync pulse
- vs  in  1  vertical sync, high during sync pulse
- rgb  in  12  pixel {R[11:8],G[7:4],B[3:0]}
- we  out  1  VRAM write enable
- waddr  out  DW  VRAM write address
- wdata  out  12  VRAM write data
- busy  out  1  high in WAIT_VS and CAPTURE
- done  out  1  one-cycle pulse, frame fully written
- frame_err  out  1  sticky: frame ended early; cleared by start

## Operation
- Input stage: hs, vs, rgb registered once (hs_q, vs_q, rgb_q); edges detected on hs_q/vs_q against a second delayed copy.
- h_cnt: cleared to 0 on the cycle hs_q first samples high, else increments (saturates at 2047). x = h_cnt - (H_SYNC+H_BP); active when 0 <= x < H_ACTIVE.
- v_cnt: increments on each hs rising edge; cleared to 0 on vs rising edge (clear wins if both edges coincide). y = v_cnt - (V_SYNC+V_BP); active when 0 <= y < V_ACTIVE.
- Sample point: x, y active and x mod SCALE = 0 and y mod SCALE = 0.
- waddr: incremental counter, 0 at frame start, +1 after each write; equals (y/SCALE)*H_LEN + x/SCALE; no multiplier.
- FSM:
  - IDLE: start -> WAIT_VS, clear frame_err.
  - WAIT_VS: vs rising edge -> CAPTURE, address counter = 0.
  - CAPTURE: write at each sample point. On the write of address H_LEN*V_LEN-1 (29999): pulse done; cont=1 -> WAIT_VS, else IDLE.
  - CAPTURE + vs rising edge before 30000 writes: set frame_err, go to IDLE. No done pulse.
- start outside IDLE is ignored. Addresses >= 30000 are never written.
- All outputs reset to 0; FSM to IDLE; counters to 0. Reset mid-frame aborts immediately. The next frame needs a new start.

## Timing
- Latency: a pixel on rgb at cycle t appears on wdata/waddr with we=1 at cycle t+2 (input register, then output register).
- we is high for exactly one cycle per sample point: 200 writes per sampled line, every 4th cycle; sampled lines are every 4th active line.
- done is asserted in the same cycle as the we for address 29999.
- busy falls in the cycle after done when cont=0.
- frame_err is set in the cycle after the offending vs edge is detected.

## Structure
- Shared package vga_pkg holds the 800x600@72 timing constants (H_SYNC, H_BP, H_ACTIVE, H_FP=56, V_SYNC, V_BP, V_ACTIVE, V_FP=37), the 12-bit RGB width, and the FSM state encoding. The display-side DST uses the same constants.
- One natural sub-module, vga_sync_tracker, contains the input registers, edge detect and h_cnt/v_cnt, and outputs x/y active flags and the sample strobe. The FSM and address generator stay in vga_frame_capture.

## Test plan
- Reset and idle: rst pulsed mid-stream with start never asserted -> we, done, busy, frame_err stay 0 for 2 full frames.
- Single frame capture: start, then a 1040x666 frame whose pixel rgb = {x[5:2],y[5:2],4'h5} -> exactly 30000 writes, waddr 0..29999. The write at waddr 201 has wdata for x=4, y=4. done is coincident with waddr 29999; busy drops next cycle.
- Latency: a single distinctive pixel 12'hABC at x=0, y=0 -> we and wdata=12'hABC exactly 2 cycles after it is driven, waddr=0.
- Continuous mode: cont=1 for 3 frames -> 3 done pulses, 90000 writes, waddr restarts at 0 each frame.
- Short frame: vs pulse injected after active line 300 -> frame_err=1, no done, FSM in IDLE, and fewer than 30000 writes. A following start clears frame_err.
- Reset mid-capture: rst asserted at write 15000 -> all outputs 0 immediately. After release, no writes occur until a new start.
